// File: rtl/red_reduction_unit.sv
// Registered byte-reduction adder for the RED instruction: adds the four signed bytes of A and B.
// Optional macro RED_PARTIAL_OUT_EN exports the registered 9-bit hi/lo byte-pair sums.

// 4-bit carry-lookahead block with flattened carry equations
module red_cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      sum  = p ^ c;
   end
endmodule

// Signed byte + signed byte -> 9-bit signed; two CLA blocks plus a sign-bit stage
module red_byte_add (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [8:0] s
);
   logic c4;
   logic c8;
   logic [3:0] s_lo;
   logic [3:0] s_hi;

   red_cla4 u_cla_lo (
      .a    (a[3:0]),
      .b    (b[3:0]),
      .cin  (1'b0),
      .sum  (s_lo),
      .cout (c4)
   );

   red_cla4 u_cla_hi (
      .a    (a[7:4]),
      .b    (b[7:4]),
      .cin  (c4),
      .sum  (s_hi),
      .cout (c8)
   );

   // Bit 8 adds the replicated sign bits, so it never overflows
   always_comb begin
      s = {a[7] ^ b[7] ^ c8, s_hi, s_lo};
   end
endmodule

// 9-bit signed + 9-bit signed -> 10-bit signed; two CLA blocks plus a 2-bit lookahead tail
module red_tot_add (
   input  logic [8:0] hi,
   input  logic [8:0] lo,
   output logic [9:0] tot
);
   logic       c4;
   logic       c8;
   logic [3:0] s_lo;
   logic [3:0] s_mid;
   logic       g8;
   logic       p8;
   logic       c9;

   red_cla4 u_cla_lo (
      .a    (hi[3:0]),
      .b    (lo[3:0]),
      .cin  (1'b0),
      .sum  (s_lo),
      .cout (c4)
   );

   red_cla4 u_cla_mid (
      .a    (hi[7:4]),
      .b    (lo[7:4]),
      .cin  (c4),
      .sum  (s_mid),
      .cout (c8)
   );

   // Bits 8 and 9 share operands (sign extension), hence one g/p pair
   always_comb begin
      g8  = hi[8] & lo[8];
      p8  = hi[8] ^ lo[8];
      c9  = g8 | (p8 & c8);
      tot = {p8 ^ c9, p8 ^ c8, s_mid, s_lo};
   end
endmodule

module red_reduction_unit #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Sum,
`ifdef RED_PARTIAL_OUT_EN
   output logic [8:0]       hi_sum,
   output logic [8:0]       lo_sum,
`endif
   output logic             out_valid
);
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned PART_W = BYTE_W + 1;
   localparam int unsigned TOT_W  = BYTE_W + 2;

   logic [WIDTH-1:0]  op_a;
   logic [WIDTH-1:0]  op_b;
   logic [PART_W-1:0] hi;
   logic [PART_W-1:0] lo;
   logic [TOT_W-1:0]  tot;

   logic [WIDTH-1:0]  sum_d;
   logic [WIDTH-1:0]  sum_q;
   logic              out_valid_d;
   logic              out_valid_q;

   // Zero operands when not qualified so unknown inputs cannot reach the datapath
   always_comb begin
      op_a = in_valid ? A : '0;
      op_b = in_valid ? B : '0;
   end

   red_byte_add u_hi_add (
      .a (op_a[15:8]),
      .b (op_b[15:8]),
      .s (hi)
   );

   red_byte_add u_lo_add (
      .a (op_a[7:0]),
      .b (op_b[7:0]),
      .s (lo)
   );

   red_tot_add u_tot_add (
      .hi  (hi),
      .lo  (lo),
      .tot (tot)
   );

   always_comb begin
      sum_d       = sum_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         sum_d = {{(WIDTH-TOT_W){tot[TOT_W-1]}}, tot};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         sum_q       <= sum_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign Sum       = sum_q;
   assign out_valid = out_valid_q;

`ifdef RED_PARTIAL_OUT_EN
   logic [PART_W-1:0] hi_sum_d;
   logic [PART_W-1:0] hi_sum_q;
   logic [PART_W-1:0] lo_sum_d;
   logic [PART_W-1:0] lo_sum_q;

   always_comb begin
      hi_sum_d = hi_sum_q;
      lo_sum_d = lo_sum_q;
      if (in_valid) begin
         hi_sum_d = hi;
         lo_sum_d = lo;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_sum_q <= '0;
         lo_sum_q <= '0;
      end else begin
         hi_sum_q <= hi_sum_d;
         lo_sum_q <= lo_sum_d;
      end
   end

   assign hi_sum = hi_sum_q;
   assign lo_sum = lo_sum_q;
`else
   // Partial sums stay internal in this build
`endif
endmodule

// File: tb/tb_red_reduction_unit.sv
// Self-checking bench for red_reduction_unit: vector table, corner sequences, random vs. arithmetic model.
module tb_red_reduction_unit;
   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] A;
   logic [15:0] B;
   logic [15:0] Sum;
   logic        out_valid;
`ifdef RED_PARTIAL_OUT_EN
   logic [8:0]  hi_sum;
   logic [8:0]  lo_sum;
`endif

   int checks;
   int errors;
   logic [15:0] exp_sum;
   logic        exp_valid;

   red_reduction_unit #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .Sum       (Sum),
`ifdef RED_PARTIAL_OUT_EN
      .hi_sum    (hi_sum),
      .lo_sum    (lo_sum),
`endif
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp;
   } vec_t;

   function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] b);
      int t;
      t = int'($signed(a[15:8])) + int'($signed(a[7:0])) + int'($signed(b[15:8])) + int'($signed(b[7:0]));
      return 16'(t);
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive on the falling edge, then sample 1 ns after the following rising edge
   task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      in_valid = v;
      A = a;
      B = b;
      @(posedge clk);
      #1;
      if (rst_n) begin
         if (v) exp_sum = ref_sum(a, b);
         exp_valid = v;
      end
   endtask

   task automatic chk_state(input string name);
      chk({name, "_sum"}, Sum, exp_sum);
      chk({name, "_valid"}, 16'(out_valid), 16'(exp_valid));
   endtask

   vec_t vecs[7];

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      A         = '0;
      B         = '0;
      exp_sum   = '0;
      exp_valid = 1'b0;

      vecs[0] = '{16'h0001, 16'h0001, 16'h0002};
      vecs[1] = '{16'h0F0F, 16'h00F0, 16'h000E};
      vecs[2] = '{16'hFFFF, 16'h0001, 16'hFFFF};
      vecs[3] = '{16'h1234, 16'h5678, 16'h0114};
      vecs[4] = '{16'hABCD, 16'hDCBA, 16'hFF0E};
      vecs[5] = '{16'h8080, 16'h8080, 16'hFE00};
      vecs[6] = '{16'h7F7F, 16'h7F7F, 16'h01FC};

      // Reset held: valid inputs must not be captured
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 16'h1111 * 16'(i + 1), 16'h2222);
         chk("reset_hold_sum", Sum, 16'h0000);
         chk("reset_hold_valid", 16'(out_valid), 16'h0000);
      end
      // Release mid-cycle; first capture on the next rising edge
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 16'h0001, 16'h0001);
      chk("first_capture_sum", Sum, 16'h0002);
      chk("first_capture_valid", 16'(out_valid), 16'h0001);

      // Vector table
      foreach (vecs[i]) begin
         cycle(1'b1, vecs[i].a, vecs[i].b);
         chk($sformatf("vec%0d_sum", i), Sum, vecs[i].exp);
         chk($sformatf("vec%0d_valid", i), 16'(out_valid), 16'h0001);
`ifdef RED_PARTIAL_OUT_EN
         if (vecs[i].a == 16'h8080 && vecs[i].b == 16'h8080) begin
            chk("partial_hi", 16'(hi_sum), 16'h0100);
            chk("partial_lo", 16'(lo_sum), 16'h0100);
         end
`endif
      end

      // Valid pattern 1,1,0,1; gap carries unknown operands and must hold Sum
      cycle(1'b1, 16'h0102, 16'h0304);
      chk("hold_p0_sum", Sum, 16'h000A);
      chk("hold_p0_valid", 16'(out_valid), 16'h0001);
      cycle(1'b1, 16'hF0F0, 16'h0A0B);
      chk("hold_p1_sum", Sum, 16'hFFF5);
      chk("hold_p1_valid", 16'(out_valid), 16'h0001);
      cycle(1'b0, 16'hxxxx, 16'hxxxx);
      chk("hold_gap_sum", Sum, 16'hFFF5);
      chk("hold_gap_valid", 16'(out_valid), 16'h0000);
      cycle(1'b1, 16'h4040, 16'hC0C0);
      chk("hold_p3_sum", Sum, 16'h0000);
      chk("hold_p3_valid", 16'(out_valid), 16'h0001);

      // Async reset between edges while a result is presented
      cycle(1'b1, 16'h7F7F, 16'h0101);
      chk_state("pre_async");
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_clear_sum", Sum, 16'h0000);
      chk("async_clear_valid", 16'(out_valid), 16'h0000);
      exp_sum   = '0;
      exp_valid = 1'b0;
      cycle(1'b1, 16'h1234, 16'h4321);
      chk_state("async_held");
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 16'h8001, 16'h7F02);
      chk_state("post_async");

      // Random traffic against the arithmetic model
      for (int i = 0; i < 300; i++) begin
         cycle(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom));
         chk("random", Sum, exp_sum);
         chk("random_valid", 16'(out_valid), 16'(exp_valid));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
